lcd_char_sink: RTL and testbench

LCD_CHAR_SINK -- requirements
Module: lcd_char_sink

---
 rtl/lcd_char_sink_pkg.sv | 53 +++++
 rtl/lcd_char_sink_if.sv | 10 +
 rtl/lcd_sink_sync.sv | 64 ++++++
 rtl/lcd_char_sink.sv | 173 +++++++++++++++++
 tb/tb_lcd_char_sink.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lcd_char_sink_pkg.sv
// Shared types, opcode masks and constants for the LCD character sink.
// Included by every file of the block through import lcd_char_sink_pkg::*.
package lcd_char_sink_pkg;

  localparam int         RAM_DEPTH = 32;
  localparam int         ADDR_W    = $clog2(RAM_DEPTH);
  localparam logic [7:0] BLANK     = 8'h20;

  // Command opcodes as value/mask pairs; a byte matches when (byte & MASK) == VAL.
  localparam logic [7:0] CLR_VAL   = 8'h01, CLR_MASK   = 8'hFF;
  localparam logic [7:0] HOME_VAL  = 8'h02, HOME_MASK  = 8'hFE;
  localparam logic [7:0] ENTRY_VAL = 8'h04, ENTRY_MASK = 8'hFC;
  localparam logic [7:0] DISP_VAL  = 8'h08, DISP_MASK  = 8'hF8;
  localparam logic [7:0] FUNC_VAL  = 8'h20, FUNC_MASK  = 8'hE0;
  localparam logic [7:0] ADDR_VAL  = 8'h80, ADDR_MASK  = 8'h80;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DECODE,
    ST_CLEAR
  } state_e;

  typedef enum logic [2:0] {
    OP_DATA,
    OP_CLR,
    OP_HOME,
    OP_ENTRY,
    OP_DISP,
    OP_FUNC,
    OP_ADDR,
    OP_NOP
  } op_e;

  typedef struct packed {
    logic       rs;
    logic       rw;
    logic [7:0] data;
  } xfer_t;

  function automatic op_e decode_op(input xfer_t x);
    op_e op;
    op = OP_NOP;
    if (x.rs)                                     op = OP_DATA;
    else if ((x.data & CLR_MASK)   == CLR_VAL)    op = OP_CLR;
    else if ((x.data & HOME_MASK)  == HOME_VAL)   op = OP_HOME;
    else if ((x.data & ENTRY_MASK) == ENTRY_VAL)  op = OP_ENTRY;
    else if ((x.data & DISP_MASK)  == DISP_VAL)   op = OP_DISP;
    else if ((x.data & FUNC_MASK)  == FUNC_VAL)   op = OP_FUNC;
    else if ((x.data & ADDR_MASK)  == ADDR_VAL)   op = OP_ADDR;
    return op;
  endfunction

endpackage

// File: rtl/lcd_char_sink_if.sv
// LCD initiator pin bundle: the initiator drives it (master), the sink samples it (slave).
interface lcd_char_sink_if;
  logic [7:0] LCD_DATA;
  logic       LCD_RS;
  logic       LCD_RW;
  logic       LCD_EN;

  modport master (output LCD_DATA, LCD_RS, LCD_RW, LCD_EN);
  modport slave  (input  LCD_DATA, LCD_RS, LCD_RW, LCD_EN);
endinterface

// File: rtl/lcd_sink_sync.sv
// Pin synchronizer and LCD_EN falling-edge detector; with LCD_CHAR_SINK_TIMING_CHK_EN
// it also flags a falling edge whose synchronized high width was below MIN_EN_HIGH.
module lcd_sink_sync
  import lcd_char_sink_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int MIN_EN_HIGH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  lcd_char_sink_if.slave        pins,
  output xfer_t                 xfer_o,
`ifdef LCD_CHAR_SINK_TIMING_CHK_EN
  output logic                  short_o,
`endif
  output logic                  fall_o
);

  typedef struct packed {
    logic  en;
    xfer_t x;
  } samp_t;

  samp_t sync_q [SYNC_STAGES];
  logic  en_prev_q;
  logic  en_s;

  // NOTE: sequential state uses non-blocking assignments so every stage samples the previous stage's old value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      en_prev_q <= 1'b0;
    end else begin
      sync_q[0] <= {pins.LCD_EN, pins.LCD_RS, pins.LCD_RW, pins.LCD_DATA};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      en_prev_q <= en_s;
    end
  end

  assign en_s   = sync_q[SYNC_STAGES-1].en;
  assign xfer_o = sync_q[SYNC_STAGES-1].x;
  assign fall_o = en_prev_q && !en_s;

`ifdef LCD_CHAR_SINK_TIMING_CHK_EN
  localparam int CNT_W = $clog2(MIN_EN_HIGH + 1);

  logic [CNT_W-1:0] hi_cnt_q, hi_cnt_d;

  // Saturates at MIN_EN_HIGH: any longer pulse is already legal.
  always_comb begin
    hi_cnt_d = hi_cnt_q;
    if (!en_s)                                hi_cnt_d = '0;
    else if (hi_cnt_q != CNT_W'(MIN_EN_HIGH)) hi_cnt_d = hi_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hi_cnt_q <= '0;
    else        hi_cnt_q <= hi_cnt_d;
  end

  assign short_o = fall_o && (hi_cnt_q < CNT_W'(MIN_EN_HIGH));
`endif

endmodule

// File: rtl/lcd_char_sink.sv
// HD44780-style character sink: decodes LCD bus transfers into a 32-entry display RAM.
// Define LCD_CHAR_SINK_TIMING_CHK_EN to add the EN-width checker and the en_err port.
module lcd_char_sink
  import lcd_char_sink_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int MIN_EN_HIGH = 8
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic [7:0] LCD_DATA,
  input  logic       LCD_RS,
  input  logic       LCD_RW,
  input  logic       LCD_EN,
  input  logic [4:0] rd_addr,
  output logic [7:0] rd_char,
  output logic [4:0] cursor,
  output logic       disp_on,
  output logic       busy,
  output logic       cmd_stb,
  output logic       ovr_err,
`ifdef LCD_CHAR_SINK_TIMING_CHK_EN
  output logic       en_err,
`endif
  output logic       rw_err
);

  lcd_char_sink_if pins_if ();
  assign pins_if.LCD_DATA = LCD_DATA;
  assign pins_if.LCD_RS   = LCD_RS;
  assign pins_if.LCD_RW   = LCD_RW;
  assign pins_if.LCD_EN   = LCD_EN;

  xfer_t xfer_s;
  logic  fall_s;

`ifdef LCD_CHAR_SINK_TIMING_CHK_EN
  logic short_s;
  logic en_err_q;
`endif

  lcd_sink_sync #(
    .SYNC_STAGES (SYNC_STAGES),
    .MIN_EN_HIGH (MIN_EN_HIGH)
  ) u_sync (
    .clk     (iCLK),
    .rst_n   (iRST_N),
    .pins    (pins_if),
    .xfer_o  (xfer_s),
`ifdef LCD_CHAR_SINK_TIMING_CHK_EN
    .short_o (short_s),
`endif
    .fall_o  (fall_s)
  );

  state_e            state_q, state_d;
  xfer_t             cap_q;
  op_e               op;
  logic [ADDR_W-1:0] cursor_q, cursor_d, clr_idx_q, clr_idx_d;
  logic              inc_q, inc_d, disp_q, disp_d;
  logic              rw_err_q, ovr_err_q;
  logic              accept, drop_busy;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_wa;
  logic [7:0]        ram_wd;
  logic [7:0]        rd_char_q;
  logic [7:0]        ram_q [RAM_DEPTH];

  assign op = decode_op(cap_q);

  // A clear being decoded this cycle also owns the next cycles, so a coincident edge is dropped.
  assign accept    = fall_s && !xfer_s.rw && (state_q != ST_CLEAR) &&
                     !((state_q == ST_DECODE) && (op == OP_CLR));
  assign drop_busy = fall_s && !xfer_s.rw && !accept;

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (accept) state_d = ST_DECODE;
      ST_DECODE: begin
        if (op == OP_CLR) state_d = ST_CLEAR;
        else if (accept)  state_d = ST_DECODE;
        else              state_d = ST_IDLE;
      end
      ST_CLEAR:  if (clr_idx_q == ADDR_W'(RAM_DEPTH - 1)) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cmd_stb = (state_q == ST_DECODE);
    busy    = (state_q == ST_CLEAR);
    ram_we  = 1'b0;
    ram_wa  = cursor_q;
    ram_wd  = cap_q.data;
    if ((state_q == ST_DECODE) && (op == OP_DATA)) ram_we = 1'b1;
    if (state_q == ST_CLEAR) begin
      ram_we = 1'b1;
      ram_wa = clr_idx_q;
      ram_wd = BLANK;
    end
  end

  always_comb begin
    cursor_d  = cursor_q;
    inc_d     = inc_q;
    disp_d    = disp_q;
    clr_idx_d = clr_idx_q;
    if (state_q == ST_DECODE) begin
      case (op)
        OP_DATA:  cursor_d = inc_q ? cursor_q + 1'b1 : cursor_q - 1'b1;
        OP_CLR:   begin
          cursor_d  = '0;
          inc_d     = 1'b1;
          clr_idx_d = '0;
        end
        OP_HOME:  cursor_d = '0;
        OP_ENTRY: inc_d    = cap_q.data[1];
        OP_DISP:  disp_d   = cap_q.data[2];
        OP_ADDR:  cursor_d = {cap_q.data[6], cap_q.data[3:0]};
        default:  ;
      endcase
    end
    if (state_q == ST_CLEAR) clr_idx_d = clr_idx_q + 1'b1;
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      cursor_q  <= '0;
      inc_q     <= 1'b1;
      disp_q    <= 1'b0;
      clr_idx_q <= '0;
      cap_q     <= '0;
      rw_err_q  <= 1'b0;
      ovr_err_q <= 1'b0;
    end else begin
      cursor_q  <= cursor_d;
      inc_q     <= inc_d;
      disp_q    <= disp_d;
      clr_idx_q <= clr_idx_d;
      if (accept) cap_q <= xfer_s;
      rw_err_q  <= fall_s && xfer_s.rw;
      ovr_err_q <= drop_busy;
    end
  end

`ifdef LCD_CHAR_SINK_TIMING_CHK_EN
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) en_err_q <= 1'b0;
    else         en_err_q <= short_s;
  end
  assign en_err = en_err_q;
`endif

  // NOTE: the character store has no reset so it maps onto plain RAM; contents are defined only after a clear.
  always_ff @(posedge iCLK) begin
    if (ram_we) ram_q[ram_wa] <= ram_wd;
    rd_char_q <= ram_q[rd_addr];
  end

  assign rd_char = rd_char_q;
  assign cursor  = cursor_q;
  assign disp_on = disp_q;
  assign ovr_err = ovr_err_q;
  assign rw_err  = rw_err_q;

endmodule

// File: tb/tb_lcd_char_sink.sv
// Self-checking bench for lcd_char_sink: directed LCD transfers, a per-cycle reference model
// and literal spot checks. Exercises en_err when LCD_CHAR_SINK_TIMING_CHK_EN is defined.
module tb_lcd_char_sink;

  localparam int SYNC_STAGES = 2;
  localparam int MIN_EN_HIGH = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] rd_addr = '0;
  logic [7:0] rd_char;
  logic [4:0] cursor;
  logic       disp_on, busy, cmd_stb, ovr_err, rw_err;
`ifdef LCD_CHAR_SINK_TIMING_CHK_EN
  logic       en_err;
`endif

  lcd_char_sink_if bus ();

  lcd_char_sink #(
    .SYNC_STAGES (SYNC_STAGES),
    .MIN_EN_HIGH (MIN_EN_HIGH)
  ) dut (
    .iCLK     (clk),
    .iRST_N   (rst_n),
    .LCD_DATA (bus.LCD_DATA),
    .LCD_RS   (bus.LCD_RS),
    .LCD_RW   (bus.LCD_RW),
    .LCD_EN   (bus.LCD_EN),
    .rd_addr  (rd_addr),
    .rd_char  (rd_char),
    .cursor   (cursor),
    .disp_on  (disp_on),
    .busy     (busy),
    .cmd_stb  (cmd_stb),
    .ovr_err  (ovr_err),
`ifdef LCD_CHAR_SINK_TIMING_CHK_EN
    .en_err   (en_err),
`endif
    .rw_err   (rw_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: display state as the command set defines it, plus a schedule of
  // transfers keyed by the clock edge on which their strobe is due.
  typedef struct {
    int         edge_no;
    logic       rs;
    logic       rw;
    logic [7:0] data;
    int         width;
  } ev_t;

  ev_t        sched[$];
  ev_t        apply_ev;
  bit         have_apply = 0;
  int         cyc = 0;
  bit         chk_on = 0;
  int         clr_edge = -1000;
  int         cursor_m = 0;
  bit         inc_m = 1;
  bit         disp_m = 0;
  logic [7:0] ram_m [32];

  int stb_seen = 0, ovr_seen = 0, rw_seen = 0, en_seen = 0;

  always @(posedge clk) cyc++;

  task automatic model_apply(input ev_t x, input int e);
    logic [7:0] d;
    d = x.data;
    if (x.rs) begin
      ram_m[cursor_m] = d;
      cursor_m = inc_m ? (cursor_m + 1) % 32 : (cursor_m + 31) % 32;
    end else if (d == 8'h01) begin
      for (int i = 0; i < 32; i++) ram_m[i] = 8'h20;
      cursor_m = 0;
      inc_m    = 1;
      clr_edge = e;
    end else if (d[7:1] == 7'b0000001) cursor_m = 0;
    else if (d[7:2] == 6'b000001)  inc_m  = d[1];
    else if (d[7:3] == 5'b00001)   disp_m = d[2];
    else if (d[7])                 cursor_m = (d[6] ? 16 : 0) + int'(d[3:0]);
  endtask

  always @(negedge clk) begin
    bit  e_stb, e_ovr, e_rw, e_en;
    ev_t ev;
    if (rst_n && chk_on) begin
      e_stb = 0; e_ovr = 0; e_rw = 0; e_en = 0;
      if (have_apply) begin
        model_apply(apply_ev, cyc - 1);
        have_apply = 0;
      end
      if (sched.size() > 0 && sched[0].edge_no == cyc) begin
        ev = sched.pop_front();
        e_en = (ev.width < MIN_EN_HIGH);
        if (ev.rw) e_rw = 1;
        else if (cyc > clr_edge && cyc <= clr_edge + 33) e_ovr = 1;
        else begin
          e_stb = 1;
          have_apply = 1;
          apply_ev = ev;
        end
      end
      check("cmd_stb", 32'(cmd_stb), 32'(e_stb));
      check("ovr_err", 32'(ovr_err), 32'(e_ovr));
      check("rw_err",  32'(rw_err),  32'(e_rw));
`ifdef LCD_CHAR_SINK_TIMING_CHK_EN
      check("en_err",  32'(en_err),  32'(e_en));
`endif
      check("cursor",  32'(cursor),  32'(cursor_m));
      check("disp_on", 32'(disp_on), 32'(disp_m));
      check("busy",    32'(busy),    32'(cyc > clr_edge && cyc <= clr_edge + 32));
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (cmd_stb === 1'b1) stb_seen++;
      if (ovr_err === 1'b1) ovr_seen++;
      if (rw_err  === 1'b1) rw_seen++;
`ifdef LCD_CHAR_SINK_TIMING_CHK_EN
      if (en_err  === 1'b1) en_seen++;
`endif
    end
  end

  task automatic xfer(input logic rs, input logic rw, input logic [7:0] d,
                      input int width, input int gap);
    ev_t ev;
    @(negedge clk);
    bus.LCD_RS   = rs;
    bus.LCD_RW   = rw;
    bus.LCD_DATA = d;
    bus.LCD_EN   = 1'b1;
    repeat (width) @(negedge clk);
    bus.LCD_EN = 1'b0;
    ev.edge_no = cyc + SYNC_STAGES + 1;
    ev.rs = rs; ev.rw = rw; ev.data = d; ev.width = width;
    sched.push_back(ev);
    repeat (gap) @(negedge clk);
  endtask

  task automatic cmd(input logic [7:0] d);
    xfer(1'b0, 1'b0, d, 8, 6);
  endtask

  task automatic wr(input logic [7:0] d);
    xfer(1'b1, 1'b0, d, 8, 6);
  endtask

  task automatic rd_lit(input int a, input logic [7:0] exp, input string name);
    @(negedge clk);
    rd_addr = 5'(a);
    @(negedge clk);
    check(name, 32'(rd_char), 32'(exp));
  endtask

  task automatic model_reset();
    sched.delete();
    have_apply = 0;
    clr_edge = -1000;
    cursor_m = 0;
    inc_m = 1;
    disp_m = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] color [5];
    color[0] = "C"; color[1] = "O"; color[2] = "L"; color[3] = "O"; color[4] = "R";
    bus.LCD_DATA = 8'h00;
    bus.LCD_RS   = 1'b0;
    bus.LCD_RW   = 1'b0;
    bus.LCD_EN   = 1'b0;
    for (int i = 0; i < 32; i++) ram_m[i] = 'x;

    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk_on = 1;
    check("rst_cursor",  32'(cursor),  32'd0);
    check("rst_disp_on", 32'(disp_on), 32'd0);
    check("rst_busy",    32'(busy),    32'd0);
    check("rst_cmd_stb", 32'(cmd_stb), 32'd0);

    // Initialisation sequence, then "COLOR" on line 1.
    cmd(8'h38);
    cmd(8'h0C);
    xfer(1'b0, 1'b0, 8'h01, 8, 40);
    cmd(8'h06);
    cmd(8'h80);
    for (int i = 0; i < 5; i++) wr(color[i]);
    check("color_cursor",  32'(cursor),  32'd5);
    check("color_disp_on", 32'(disp_on), 32'd1);
    rd_lit(0, 8'h43, "color_ram0");
    rd_lit(1, 8'h4F, "color_ram1");
    rd_lit(2, 8'h4C, "color_ram2");
    rd_lit(3, 8'h4F, "color_ram3");
    rd_lit(4, 8'h52, "color_ram4");
    for (int i = 5; i < 32; i += 9) rd_lit(i, ram_m[i], "color_blank");

    // Line 2 addressing.
    cmd(8'hC0);
    wr(8'h31);
    check("line2_cursor", 32'(cursor), 32'd17);
    rd_lit(16, 8'h31, "line2_ram16");

    // Wrap in both directions, home, address with ignored bits, display off/on.
    cmd(8'hCF);
    check("addr31_cursor", 32'(cursor), 32'd31);
    wr(8'h41);
    check("wrap_up_cursor", 32'(cursor), 32'd0);
    cmd(8'h04);
    wr(8'h42);
    check("wrap_dn_cursor", 32'(cursor), 32'd31);
    rd_lit(31, 8'h41, "wrap_ram31");
    rd_lit(0,  8'h42, "wrap_ram0");
    cmd(8'h02);
    check("home_cursor", 32'(cursor), 32'd0);
    cmd(8'hB3);
    check("addr_ign_cursor", 32'(cursor), 32'd3);
    cmd(8'h08);
    check("disp_off", 32'(disp_on), 32'd0);
    cmd(8'h0C);

    // Clear with a data write arriving while the fill is still running.
    xfer(1'b0, 1'b0, 8'h01, 8, 1);
    xfer(1'b1, 1'b0, 8'h5A, 8, 40);
    check("ovr_count",   32'(ovr_seen), 32'd1);
    check("clr_busy",    32'(busy),     32'd0);
    check("clr_cursor",  32'(cursor),   32'd0);
    for (int i = 0; i < 32; i++) rd_lit(i, 8'h20, "clr_ram");

    // Read transfer is rejected and leaves everything alone.
    xfer(1'b1, 1'b1, 8'h55, 8, 6);
    check("rw_count",  32'(rw_seen), 32'd1);
    check("rw_cursor", 32'(cursor),  32'd0);
    rd_lit(0, 8'h20, "rw_ram0");

    // Reset while the fill is in progress.
    xfer(1'b0, 1'b0, 8'h01, 8, 10);
    check("midclr_busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1 check("rst_midclr_busy", 32'(busy), 32'd0);
    model_reset();
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_cursor",  32'(cursor),  32'd0);
    check("post_rst_disp_on", 32'(disp_on), 32'd0);
    check("post_rst_busy",    32'(busy),    32'd0);

`ifdef LCD_CHAR_SINK_TIMING_CHK_EN
    // Short EN pulse: flagged but still written.
    xfer(1'b1, 1'b0, 8'h77, 3, 6);
    check("en_err_count", 32'(en_seen), 32'd1);
    check("short_cursor", 32'(cursor),  32'd1);
    rd_lit(0, 8'h77, "short_ram0");
    check("stb_total", 32'(stb_seen), 32'd23);
`else
    check("stb_total", 32'(stb_seen), 32'd22);
`endif

    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
